// File: rtl/channel_combiner.sv
// rtl/channel_combiner.sv - sums each channel-interleaved I/Q frame into one rounded, saturated sample
// One lane per component (I or Q); the top sequences frames and owns the valid/ready handshake.

module channel_combiner_lane #(
  parameter int WIDTH = 16,
  parameter int ACC_W = 28,
  parameter int SHIFT = 11
) (
  input  logic                    i_clock,
  input  logic                    i_reset_n,
  input  logic                    i_clear,
  input  logic                    i_accept,
  input  logic                    i_first,
  input  logic                    i_close,
  input  logic signed [WIDTH-1:0] i_sample,
  output logic signed [WIDTH-1:0] o_result,
  output logic                    o_sat
);

  // One spare bit over the accumulator so the rounding constant can never overflow the sum.
  localparam int RW       = ACC_W + 1;
  localparam int SHIFT_M1 = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [RW-1:0] ROUND = (SHIFT > 0) ? (RW'(1) << SHIFT_M1) : '0;

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [WIDTH-1:0] result_q, result_d;
  logic signed [RW-1:0]    acc_ext;
  logic signed [RW-1:0]    smp_ext;
  logic signed [RW-1:0]    sum;
  logic signed [RW-1:0]    rounded;
  logic signed [WIDTH-1:0] clamped;
  logic                    over;
  logic                    under;

  always_comb begin
    acc_ext = {{(RW-ACC_W){acc_q[ACC_W-1]}}, acc_q};
    smp_ext = {{(RW-WIDTH){i_sample[WIDTH-1]}}, i_sample};
    sum     = (i_first ? '0 : acc_ext) + smp_ext;
    rounded = (sum + $signed(ROUND)) >>> SHIFT;

    // In range only when every bit above the output sign bit matches the sign.
    over  = !rounded[RW-1] && (|rounded[RW-2:WIDTH-1]);
    under =  rounded[RW-1] && !(&rounded[RW-2:WIDTH-1]);

    if (over) begin
      clamped = {1'b0, {(WIDTH-1){1'b1}}};
    end else if (under) begin
      clamped = {1'b1, {(WIDTH-1){1'b0}}};
    end else begin
      clamped = rounded[WIDTH-1:0];
    end

    acc_d = acc_q;
    if (i_clear) begin
      acc_d = '0;
    end else if (i_accept) begin
      acc_d = sum[ACC_W-1:0];
    end

    result_d = result_q;
    if (i_close) begin
      result_d = clamped;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign o_result = result_q;
  assign o_sat    = i_close && (over || under);

endmodule

module channel_combiner #(
  parameter int WIDTH        = 16,
  parameter int NUM_CHANNELS = 2048,
  parameter int SHIFT        = 11
) (
  input  logic                            i_clock,
  input  logic                            i_reset_n,
  input  logic signed [WIDTH-1:0]         i_inph,
  input  logic signed [WIDTH-1:0]         i_quad,
  input  logic                            i_valid,
  output logic                            o_ready,
  output logic signed [WIDTH-1:0]         o_inph,
  output logic signed [WIDTH-1:0]         o_quad,
  output logic                            o_valid,
  input  logic                            i_ready,
  input  logic                            i_clear,
  output logic [$clog2(NUM_CHANNELS)-1:0] o_chan,
  output logic                            o_sat
);

  localparam int CHAN_W = $clog2(NUM_CHANNELS);
  localparam int ACC_W  = WIDTH + CHAN_W + 1;
  localparam logic [CHAN_W-1:0] LAST = CHAN_W'(NUM_CHANNELS - 1);

  logic [CHAN_W-1:0] chan_q, chan_d;
  logic              valid_q, valid_d;
  logic              sat_q, sat_d;
  logic              accept;
  logic              first;
  logic              close;
  logic              inph_sat;
  logic              quad_sat;

  // Only the frame-closing sample can stall, and only behind an unconsumed result.
  assign o_ready = !((chan_q == LAST) && valid_q && !i_ready);
  assign accept  = i_valid && o_ready && !i_clear;
  assign first   = (chan_q == '0);
  assign close   = accept && (chan_q == LAST);

  channel_combiner_lane #(
    .WIDTH (WIDTH),
    .ACC_W (ACC_W),
    .SHIFT (SHIFT)
  ) u_lane_inph (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .i_clear   (i_clear),
    .i_accept  (accept),
    .i_first   (first),
    .i_close   (close),
    .i_sample  (i_inph),
    .o_result  (o_inph),
    .o_sat     (inph_sat)
  );

  channel_combiner_lane #(
    .WIDTH (WIDTH),
    .ACC_W (ACC_W),
    .SHIFT (SHIFT)
  ) u_lane_quad (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .i_clear   (i_clear),
    .i_accept  (accept),
    .i_first   (first),
    .i_close   (close),
    .i_sample  (i_quad),
    .o_result  (o_quad),
    .o_sat     (quad_sat)
  );

  always_comb begin
    chan_d  = chan_q;
    valid_d = valid_q;
    sat_d   = sat_q;
    if (i_clear) begin
      chan_d  = '0;
      valid_d = 1'b0;
      sat_d   = 1'b0;
    end else begin
      if (accept) begin
        chan_d = (chan_q == LAST) ? '0 : chan_q + CHAN_W'(1);
      end
      // A new result replaces one leaving in the same cycle, so valid stays high.
      if (close) begin
        valid_d = 1'b1;
        sat_d   = sat_q || inph_sat || quad_sat;
      end else if (valid_q && i_ready) begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      chan_q  <= '0;
      valid_q <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      chan_q  <= chan_d;
      valid_q <= valid_d;
      sat_q   <= sat_d;
    end
  end

  assign o_chan  = chan_q;
  assign o_valid = valid_q;
  assign o_sat   = sat_q;

endmodule

// File: tb/tb_channel_combiner.sv
// tb/tb_channel_combiner.sv - self-checking bench for channel_combiner
// Two instances share stimulus: SHIFT=2 for rounding/ordering, SHIFT=0 to reach saturation.

module tb_channel_combiner;

  localparam int W = 16;
  localparam int N = 4;
  localparam int FRAMES = 1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic signed [W-1:0] i_inph = '0;
  logic signed [W-1:0] i_quad = '0;
  logic                i_valid = 1'b0;
  logic                i_ready = 1'b1;
  logic                i_clear = 1'b0;

  logic                o_ready, o_valid, o_sat;
  logic signed [W-1:0] o_inph, o_quad;
  logic [1:0]          o_chan;
  logic                o_ready0, o_valid0, o_sat0;
  logic signed [W-1:0] o_inph0, o_quad0;
  logic [1:0]          o_chan0;

  channel_combiner #(.WIDTH(W), .NUM_CHANNELS(N), .SHIFT(2)) dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_inph(i_inph), .i_quad(i_quad),
    .i_valid(i_valid), .o_ready(o_ready), .o_inph(o_inph), .o_quad(o_quad),
    .o_valid(o_valid), .i_ready(i_ready), .i_clear(i_clear), .o_chan(o_chan),
    .o_sat(o_sat)
  );

  channel_combiner #(.WIDTH(W), .NUM_CHANNELS(N), .SHIFT(0)) dut0 (
    .i_clock(clk), .i_reset_n(rst_n), .i_inph(i_inph), .i_quad(i_quad),
    .i_valid(i_valid), .o_ready(o_ready0), .o_inph(o_inph0), .o_quad(o_quad0),
    .o_valid(o_valid0), .i_ready(i_ready), .i_clear(i_clear), .o_chan(o_chan0),
    .o_sat(o_sat0)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int i, input int q);
    i_valid = 1'b1;
    i_inph  = 16'(i);
    i_quad  = 16'(q);
    step();
    i_valid = 1'b0;
  endtask

  task automatic frame(input int i0, input int i1, input int i2, input int i3,
                       input int q0, input int q1, input int q2, input int q3);
    send(i0, q0);
    send(i1, q1);
    send(i2, q2);
    send(i3, q3);
  endtask

  // Reference: exact integer frame sum, floor((sum + half) / 2^sh), clamp to WIDTH.
  function automatic int floor_div(input int a, input int b);
    int q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic int model(input int sum, input int sh, output bit sat);
    int r;
    r   = (sh == 0) ? sum : floor_div(sum + (1 << (sh - 1)), 1 << sh);
    sat = 1'b0;
    if (r > 32767) begin r = 32767; sat = 1'b1; end
    if (r < -32768) begin r = -32768; sat = 1'b1; end
    return r;
  endfunction

  bit mon_en = 1'b0;
  int q_e2i[$], q_e2q[$], q_e0i[$], q_e0q[$];
  int n_out = 0;
  bit sat_seen2 = 1'b0;
  bit sat_seen0 = 1'b0;

  initial begin
    int fi[N];
    int fq[N];
    int fcnt;
    int si, sq;
    bit s1, s2;
    fcnt = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (i_valid && o_ready && !i_clear) begin
          fi[fcnt] = int'(i_inph);
          fq[fcnt] = int'(i_quad);
          fcnt++;
          if (fcnt == N) begin
            si = 0;
            sq = 0;
            for (int k = 0; k < N; k++) begin
              si += fi[k];
              sq += fq[k];
            end
            q_e2i.push_back(model(si, 2, s1));
            q_e2q.push_back(model(sq, 2, s2));
            sat_seen2 = sat_seen2 | s1 | s2;
            q_e0i.push_back(model(si, 0, s1));
            q_e0q.push_back(model(sq, 0, s2));
            sat_seen0 = sat_seen0 | s1 | s2;
            fcnt = 0;
          end
        end
        if (o_valid && i_ready) begin
          if (q_e2i.size() == 0) begin
            check("rand_spurious_output", 1, 0);
          end else begin
            check("rand_inph",  o_inph,  q_e2i.pop_front());
            check("rand_quad",  o_quad,  q_e2q.pop_front());
            check("rand_inph0", o_inph0, q_e0i.pop_front());
            check("rand_quad0", o_quad0, q_e0q.pop_front());
            n_out++;
          end
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ri[4][4];
    int re[4];
    int accepted;
    int cycles;

    // Reset and idle
    rst_n = 1'b0;
    repeat (3) step();
    check("rst_valid", o_valid, 0);
    check("rst_inph",  o_inph,  0);
    check("rst_quad",  o_quad,  0);
    check("rst_chan",  o_chan,  0);
    check("rst_sat",   o_sat,   0);
    rst_n = 1'b1;
    for (int c = 0; c < 100; c++) begin
      step();
      check("idle_valid", o_valid, 0);
      check("idle_ready", o_ready, 1);
      check("idle_chan",  o_chan,  0);
    end
    check("idle_inph", o_inph, 0);
    check("idle_quad", o_quad, 0);

    // Basic frame
    frame(100, 200, 300, 400, -4, -4, -4, -4);
    check("basic_valid", o_valid, 1);
    check("basic_inph",  o_inph,  250);
    check("basic_quad",  o_quad,  -4);
    check("basic_chan",  o_chan,  0);
    check("basic_inph0", o_inph0, 1000);
    check("basic_quad0", o_quad0, -16);
    step();
    check("basic_one_clock", o_valid, 0);

    // Rounding
    ri = '{'{1, 1, 0, 0}, '{-2, 0, 0, 0}, '{1, 0, 0, 0}, '{-3, 0, 0, 0}};
    re = '{1, 0, 0, -1};
    for (int t = 0; t < 4; t++) begin
      frame(ri[t][0], ri[t][1], ri[t][2], ri[t][3], 0, 0, 0, 0);
      check("round_valid", o_valid, 1);
      check("round_inph",  o_inph,  re[t]);
      check("round_quad",  o_quad,  0);
      check("round_inph0", o_inph0, ri[t][0] + ri[t][1] + ri[t][2] + ri[t][3]);
      step();
    end

    // Saturation (SHIFT=0 instance); SHIFT=2 lands exactly on the rails
    frame(32767, 32767, 32767, 32767, 0, 0, 0, 0);
    check("satp_inph0", o_inph0, 32767);
    check("satp_sat0",  o_sat0,  1);
    check("satp_inph",  o_inph,  32767);
    check("satp_sat",   o_sat,   0);
    step();
    i_clear = 1'b1;
    step();
    i_clear = 1'b0;
    check("clr_sat0", o_sat0, 0);
    frame(-32768, -32768, -32768, -32768, 0, 0, 0, 0);
    check("satn_inph0", o_inph0, -32768);
    check("satn_sat0",  o_sat0,  1);
    check("satn_inph",  o_inph,  -32768);
    check("satn_sat",   o_sat,   0);
    step();
    i_clear = 1'b1;
    step();
    i_clear = 1'b0;
    check("clr2_sat0",  o_sat0,  0);
    check("clr2_valid", o_valid0, 0);
    check("clr2_hold",  o_inph0, -32768);

    // Backpressure: only the 8th sample stalls
    i_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      i_valid = 1'b1;
      i_inph  = (k < 4) ? 16'(100 * (k + 1)) : 16'(-100 * (k - 3));
      i_quad  = (k < 4) ? 16'(4 * (k + 1)) : 16'(1);
      #1;
      check("bp_ready", o_ready, (k == 7) ? 0 : 1);
      if (k < 7) step();
    end
    check("bp_valid", o_valid, 1);
    check("bp_inph",  o_inph,  250);
    check("bp_quad",  o_quad,  10);
    repeat (3) begin
      step();
      check("bp_stall_ready", o_ready, 0);
      check("bp_hold_inph",   o_inph,  250);
      check("bp_hold_quad",   o_quad,  10);
      check("bp_chan",        o_chan,  3);
    end
    i_ready = 1'b1;
    #1;
    check("bp_release_ready", o_ready, 1);
    step();
    i_valid = 1'b0;
    check("bp_second_valid", o_valid, 1);
    check("bp_second_inph",  o_inph,  -250);
    check("bp_second_quad",  o_quad,  1);
    step();
    check("bp_drained", o_valid, 0);

    // Flush mid-frame
    send(5, 0);
    send(5, 0);
    check("flush_chan_before", o_chan, 2);
    i_clear = 1'b1;
    i_valid = 1'b1;
    i_inph  = 16'(1000);
    #1;
    check("flush_ready", o_ready, 1);
    step();
    i_clear = 1'b0;
    i_valid = 1'b0;
    check("flush_chan",  o_chan,  0);
    check("flush_valid", o_valid, 0);
    frame(8, 8, 8, 8, 0, 0, 0, 0);
    check("flush_out_valid", o_valid, 1);
    check("flush_out_inph",  o_inph,  8);
    step();
    check("flush_single", o_valid, 0);

    // Asynchronous reset with a pending result and a partial frame
    i_ready = 1'b0;
    frame(8, 8, 8, 8, 0, 0, 0, 0);
    send(3, 3);
    send(3, 3);
    check("ar_pre_valid", o_valid, 1);
    check("ar_pre_chan",  o_chan,  2);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid", o_valid, 0);
    check("ar_chan",  o_chan,  0);
    check("ar_inph",  o_inph,  0);
    step();
    rst_n   = 1'b1;
    i_ready = 1'b1;
    frame(4, 4, 4, 4, 0, 0, 0, 0);
    check("ar_fresh_inph", o_inph, 4);
    step();

    // Random frames with random gaps on both sides
    i_clear = 1'b1;
    step();
    i_clear = 1'b0;
    mon_en   = 1'b1;
    accepted = 0;
    cycles   = 0;
    while (accepted < N * FRAMES && cycles < 40000) begin
      i_valid = ($urandom_range(0, 3) != 0);
      i_inph  = 16'($urandom);
      i_quad  = 16'($urandom);
      i_ready = ($urandom_range(0, 1) == 1);
      #1;
      if (i_valid && o_ready) accepted++;
      step();
      cycles++;
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    cycles  = 0;
    while (n_out < FRAMES && cycles < 200) begin
      step();
      cycles++;
    end
    step();
    mon_en = 1'b0;
    check("rand_accepts", accepted, N * FRAMES);
    check("rand_outputs", n_out, FRAMES);
    check("rand_leftover", q_e2i.size(), 0);
    check("rand_sat",  o_sat,  sat_seen2);
    check("rand_sat0", o_sat0, sat_seen0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/channel_combiner.md
Name: channel_combiner

Overview:
Downstream of channel_modulator. Consumes its channel-interleaved I/Q stream: samples arrive in channel order 0..NUM_CHANNELS-1, repeating. Per frame (one sample from every channel) the block sums all channels, scales by 2^-SHIFT with rounding and saturation, and emits one combined I/Q sample. Valid/ready on both sides, full backpressure, no sample loss.

Parameters:
WIDTH, 16, I/Q sample width (signed two's complement), input and output.
NUM_CHANNELS, 2048, samples per frame; integer >= 2 (power of two not required).
SHIFT, 11, arithmetic right shift applied to frame sum; 0 <= SHIFT <= WIDTH+clog2(NUM_CHANNELS).

Ports:
i_clock  input  1  clock, all logic on rising edge.
i_reset_n  input  1  asynchronous active-low reset.
i_inph  input  WIDTH  input in-phase sample, signed.
i_quad  input  WIDTH  input quadrature sample, signed.
i_valid  input  1  input sample valid.
o_ready  output  1  block accepts input this cycle.
o_inph  output  WIDTH  combined in-phase sample, signed.
o_quad  output  WIDTH  combined quadrature sample, signed.
o_valid  output  1  combined sample valid.
i_ready  input  1  downstream accepts output.
i_clear  input  1  synchronous flush: abandon partial frame, drop pending output.
o_chan  output  clog2(NUM_CHANNELS)  channel index the next accepted sample is assigned to.
o_sat  output  1  sticky: a saturation has occurred since reset/clear.

Behaviour:
- Reset (i_reset_n=0, async): o_valid=0, o_inph=0, o_quad=0, o_chan=0, o_sat=0, accumulators=0. o_ready reads 1 after reset releases.
- Input accept: i_valid && o_ready at rising edge. Output transfer: o_valid && i_ready.
- o_ready (combinational from registers) = NOT(o_chan==NUM_CHANNELS-1 AND o_valid AND NOT i_ready). Only the frame-closing sample stalls, and only while the previous result is still unconsumed. Mid-frame samples are always accepted.
- Accumulators: ACC_W = WIDTH+clog2(NUM_CHANNELS)+1, signed, separate I and Q.
- On accept with o_chan==0: acc = sign-extended sample.
- On accept with o_chan>0: acc += sample.
- On every accept, o_chan increments. It wraps to 0 after NUM_CHANNELS-1.
- On accepting channel NUM_CHANNELS-1, the output registers are loaded with r = (full_sum + 2^(SHIFT-1)) >>> SHIFT. For SHIFT=0, r = full_sum. Rounding is round-half-up.
- r is saturated to [-2^(WIDTH-1), 2^(WIDTH-1)-1]. o_sat is set if either I or Q saturates.
- o_valid rises the cycle after the closing sample is accepted (latency 1 clock from last input to output valid).
- If an output transfer and a new frame close happen in the same cycle, the new result is loaded and o_valid stays 1.
- If an output transfer happens with no new frame close, o_valid goes to 0.
- While o_valid && !i_ready: o_inph/o_quad are held stable.
- i_clear=1 (sync, highest priority): o_chan=0, accumulators=0, o_valid=0, o_sat=0. A sample presented in the same cycle is discarded (o_ready still 1, nothing accumulated). Outputs are otherwise unchanged.
- i_reset_n asserted mid-frame or with o_valid=1: everything returns to reset values immediately. The partial frame and pending output are lost.
- No X propagation: i_inph/i_quad are ignored when i_valid=0.

Test Plan:
1. Reset, then idle 100 clocks with i_valid=0, i_ready=1 -> o_valid never 1, o_ready=1, o_chan=0, o_inph=o_quad=0.
2. NUM_CHANNELS=4, SHIFT=2, i_ready=1. Send I=100,200,300,400 and Q=-4,-4,-4,-4 back-to-back -> one cycle after 4th accept, o_valid=1 for exactly 1 clock with o_inph=250, o_quad=-4; o_chan back to 0.
3. Rounding, NUM_CHANNELS=4, SHIFT=2:
   - I=1,1,0,0 -> o_inph=1.
   - I=-2,0,0,0 -> 0.
   - I=1,0,0,0 -> 0.
   - I=-3,0,0,0 -> -1.
4. Saturation, NUM_CHANNELS=4, SHIFT=0:
   - I=32767 x4 -> o_inph=32767, o_sat=1.
   - After i_clear, I=-32768 x4 -> o_inph=-32768, o_sat=1.
   - i_clear -> o_sat=0.
5. Backpressure, NUM_CHANNELS=4, SHIFT=2:
   - i_ready=0 and 8 consecutive valid samples -> o_ready=0 only while offering the 8th sample; first result held stable.
   - Raise i_ready -> both results delivered in order.
   - 1000 random frames with random i_valid/i_ready gaps -> output count = 1000 and all values match the reference model.
6. Flush and reset mid-frame:
   - i_clear after 2 of 4 samples, then 4 samples of I=8 -> single output o_inph=8.
   - i_reset_n pulsed low with o_valid=1 -> o_valid=0 asynchronously, o_chan=0.
